deal_sequencer: RTL and testbench
=================================

# deal_sequencer

Sequences one round of blackjack: initial four-card deal, player hit/stand turn, dealer draw-to-17, and result. It arbitrates the single free-running card RNG value between the player and dealer hands. It also maintains both hand totals with soft-ace handling. It sits between the PS/2 key decoder (hit/stand/deal pulses), the card RNG, and the score converter / display controller.

## Interface
Parameters:
- DEALER_STAND, default 17: dealer stands at effective total ≥ this value; soft 17 stands.
- MAX_CARDS, default 11: maximum cards per hand; further draw requests are ignored.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  **synchronous, active-high**; one clock, no other clock domains
- deal_pressed  in  1  single-cycle pulse, starts a round
- hit_pressed  in  1  single-cycle pulse, player requests a card
- stand_pressed  in  1  single-cycle pulse, player ends turn
- card_value  in  4  RNG rank; 1 = Ace, 2–10 pip, 11–13 = J/Q/K; 0, 14, 15 invalid
- player_score  out  5  player effective total
- dealer_score  out  5  dealer effective total
- game_state  out  3  0 IDLE, 1 DEALING, 2 PLAYER, 3 DEALER, 4 P_WIN, 5 D_WIN, 6 PUSH
- show_dealer_first  out  1  1 = only the dealer's first card is visible
- card_taken  out  1  one-cycle pulse when a card is accepted
- card_to_dealer  out  1  destination of the accepted card, valid with card_taken

## Operation
- Card points: rank 1 → 1 with ace flag set; 2–10 → face value; 11–13 → 10.
- Effective total = raw + 10 if the hand holds an ace and raw ≤ 11; otherwise raw. Raw totals saturate at 31.
- FSM states: IDLE → DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → PLAYER → (P_DRAW ↔ PLAYER) → DEALER → (D_DRAW ↔ DEALER) → RESULT.
- Draw states (DEAL_*, P_DRAW, D_DRAW):
  - Accept card_value in the current cycle if it is 1–13.
  - Otherwise remain in the state and retry next cycle. There is no timeout.
- IDLE or RESULT + deal_pressed: clear both hands, go to DEAL_P1. deal_pressed is ignored in all other states.
- After DEAL_D2:
  - Player effective = 21 → go directly to DEALER.
  - Otherwise → PLAYER.
- PLAYER state:
  - stand_pressed → DEALER.
  - hit_pressed → P_DRAW.
  - Both asserted in the same cycle → stand wins.
  - hit is ignored if the player hand already holds MAX_CARDS cards.
- After P_DRAW:
  - Player effective > 21 → RESULT with D_WIN; no dealer draws.
  - Player effective = 21 → DEALER automatically.
  - Otherwise → PLAYER.
- DEALER state:
  - Dealer effective < DEALER_STAND and card count < MAX_CARDS → D_DRAW, then back to DEALER.
  - Otherwise → RESULT.
- Result evaluation:
  - Dealer > 21 → P_WIN.
  - Player > dealer → P_WIN.
  - Player < dealer → D_WIN.
  - Equal → PUSH.
- show_dealer_first:
  - Set on entry to DEAL_D2.
  - Cleared on entry to DEALER, or on a player bust going to RESULT.
- game_state:
  - DEALING for all DEAL_* states.
  - PLAYER for PLAYER and P_DRAW.
  - DEALER for DEALER and D_DRAW.
  - RESULT outputs its latched outcome code.

## Timing
- Reset values:
  - FSM in IDLE.
  - player_score = 0, dealer_score = 0, game_state = 0.
  - show_dealer_first = 0, card_taken = 0, card_to_dealer = 0.
  - Hands and counts cleared.
- Reset asserted mid-round aborts the round; outputs take their reset values at the next edge.
- Scores, game_state, card_taken and card_to_dealer are all registered.
- An accepted card is reflected in its score one cycle after acceptance, together with the card_taken pulse.
- With all-valid RNG values, the round timing is:
  - deal_pressed at cycle n gives card_taken pulses at n+2, n+3, n+4 and n+5, going P, D, P, D.
  - Each hit adds 2 cycles from the press to the card_taken pulse.
  - Each dealer draw takes 2 cycles (DEALER evaluate + D_DRAW).
- Decisions in PLAYER and DEALER use the registered totals. No combinational path exists from card_value to any output.

## Structure
- Shared package bj_pkg holds:
  - state and game_state encodings;
  - ACE_RANK = 1, FACE_POINTS = 10, BJ_TARGET = 21;
  - a rank-to-points function.
- Sub-module hand_accumulator is instantiated twice (player, dealer):
  - inputs: clear, add, rank;
  - outputs: raw total, ace flag, effective total, card count.
- The FSM top handles sequencing and RNG arbitration only.

## Test plan
- Reset, then deal with RNG sequence 10, 5, 1, 6:
  - player_score = 21 immediately; state goes to DEALER.
  - Dealer 11 draws 7 → 18, stands.
  - Expect P_WIN (game_state = 4).
- Deal 10, 10, 7, 7, then stand:
  - Player 17, dealer 17; dealer does not draw.
  - Expect PUSH (6); show_dealer_first goes 0 on entry to DEALER.
- Deal 10, 9, 6, 8, then hit with 10:
  - Player raw 26 → D_WIN (5).
  - No further card_taken pulses; show_dealer_first = 0.
- Card_value held at 0, then 14, for 5 cycles during DEAL_P1:
  - No card_taken and FSM stalls.
  - Releasing with 3 gives player_score = 3 one cycle later.
- hit_pressed and stand_pressed in the same PLAYER cycle:
  - Goes to DEALER; player count unchanged.
- Dealer soft 17 (1, 6) stands; dealer 1, 5 then draws 10 → hard 16, draws again.
- Reset asserted in D_DRAW:
  - All outputs 0 at the next edge.
  - deal_pressed ignored while reset is high.

Source files
------------

// File: rtl/bj_pkg.sv
// Shared encodings, constants and scoring helpers for the blackjack round sequencer.
package bj_pkg;

    localparam logic [3:0] ACE_RANK    = 4'd1;
    localparam logic [4:0] FACE_POINTS = 5'd10;
    localparam logic [4:0] BJ_TARGET   = 5'd21;
    localparam logic [4:0] SCORE_MAX   = 5'd31;

    // Internal sequencer states; each draw state owns exactly one card.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEAL_P1 = 4'd1,
        ST_DEAL_D1 = 4'd2,
        ST_DEAL_P2 = 4'd3,
        ST_DEAL_D2 = 4'd4,
        ST_PLAYER  = 4'd5,
        ST_P_DRAW  = 4'd6,
        ST_DEALER  = 4'd7,
        ST_D_DRAW  = 4'd8,
        ST_RESULT  = 4'd9
    } state_e;

    // Externally visible game_state codes.
    typedef enum logic [2:0] {
        GS_IDLE    = 3'd0,
        GS_DEALING = 3'd1,
        GS_PLAYER  = 3'd2,
        GS_DEALER  = 3'd3,
        GS_P_WIN   = 3'd4,
        GS_D_WIN   = 3'd5,
        GS_PUSH    = 3'd6
    } gstate_e;

    // RNG ranks 0, 14 and 15 are not cards and must be retried.
    function automatic logic rank_valid(input logic [3:0] rank);
        return (rank >= 4'd1) && (rank <= 4'd13);
    endfunction

    // Ace counts 1 here; the soft +10 is applied by effective_total.
    function automatic logic [4:0] rank_points(input logic [3:0] rank);
        logic [4:0] pts;
        if (!rank_valid(rank))
            pts = 5'd0;
        else if (rank <= 4'd10)
            pts = {1'b0, rank};
        else
            pts = FACE_POINTS;
        return pts;
    endfunction

    // Raw total clamped to the 5-bit score range.
    function automatic logic [4:0] sat_total(input logic [5:0] sum);
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[4:0];
    endfunction

    // One ace is promoted to 11 whenever that does not bust the hand.
    function automatic logic [4:0] effective_total(input logic [4:0] raw, input logic ace);
        return (ace && (raw <= 5'd11)) ? (raw + FACE_POINTS) : raw;
    endfunction

    // Final outcome from the two effective totals (player bust handled earlier).
    function automatic gstate_e judge(input logic [4:0] p_eff, input logic [4:0] d_eff);
        gstate_e res;
        if (d_eff > BJ_TARGET)
            res = GS_P_WIN;
        else if (p_eff > d_eff)
            res = GS_P_WIN;
        else if (p_eff < d_eff)
            res = GS_D_WIN;
        else
            res = GS_PUSH;
        return res;
    endfunction

    // Collapse internal states onto the external game_state code.
    function automatic logic [2:0] state_to_gs(input state_e st, input gstate_e outcome);
        logic [2:0] gs;
        case (st)
            ST_DEAL_P1, ST_DEAL_D1,
            ST_DEAL_P2, ST_DEAL_D2: gs = GS_DEALING;
            ST_PLAYER, ST_P_DRAW:   gs = GS_PLAYER;
            ST_DEALER, ST_D_DRAW:   gs = GS_DEALER;
            ST_RESULT:              gs = outcome;
            default:                gs = GS_IDLE;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/hand_accumulator.sv
// One blackjack hand: saturating raw total, ace flag, effective total and card count.
module hand_accumulator
    import bj_pkg::*;
#(
    parameter int MAX_CARDS = 11,
    parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             add_i,
    input  logic [3:0]       rank_i,
    output logic [4:0]       raw_o,
    output logic             ace_o,
    output logic [4:0]       eff_o,
    output logic [CNT_W-1:0] count_o,
    output logic [4:0]       eff_next_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARDS);

    logic [4:0]       raw_q, raw_d;
    logic             ace_q, ace_d;
    logic [4:0]       eff_q, eff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       sum;

    // Next hand contents; a full hand silently drops further cards.
    always_comb begin
        raw_d = raw_q;
        ace_d = ace_q;
        cnt_d = cnt_q;
        sum   = {1'b0, raw_q} + {1'b0, rank_points(rank_i)};
        if (clear_i) begin
            raw_d = 5'd0;
            ace_d = 1'b0;
            cnt_d = '0;
        end else if (add_i && rank_valid(rank_i) && (cnt_q < MAX_CNT)) begin
            raw_d = sat_total(sum);
            ace_d = ace_q | (rank_i == ACE_RANK);
            cnt_d = cnt_q + CNT_W'(1);
        end
        eff_d = effective_total(raw_d, ace_d);
    end

    // Hand registers; effective total is registered alongside the raw total.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q <= 5'd0;
            ace_q <= 1'b0;
            eff_q <= 5'd0;
            cnt_q <= '0;
        end else begin
            raw_q <= raw_d;
            ace_q <= ace_d;
            eff_q <= eff_d;
            cnt_q <= cnt_d;
        end
    end

    assign raw_o      = raw_q;
    assign ace_o      = ace_q;
    assign eff_o      = eff_q;
    assign count_o    = cnt_q;
    assign eff_next_o = eff_d;

endmodule

// File: rtl/deal_sequencer.sv
// Blackjack round sequencer: deal, player turn, dealer draw-to-stand, result.
// Arbitrates the free-running card RNG between the player and dealer hands.
module deal_sequencer
    import bj_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_pressed,
    input  logic       hit_pressed,
    input  logic       stand_pressed,
    input  logic [3:0] card_value,
    output logic [4:0] player_score,
    output logic [4:0] dealer_score,
    output logic [2:0] game_state,
    output logic       show_dealer_first,
    output logic       card_taken,
    output logic       card_to_dealer
);

    localparam int               CNT_W     = $clog2(MAX_CARDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CARDS);
    localparam logic [4:0]       STAND_PTS = 5'(DEALER_STAND);

    state_e     state_q, state_d;
    gstate_e    outcome_q, outcome_d;
    logic       show_q, show_d;
    logic [2:0] gs_q, gs_d;
    logic       taken_q, to_dealer_q;

    logic             p_clear, p_add, d_clear, d_add;
    logic [4:0]       p_raw, p_eff, p_eff_next;
    logic [4:0]       d_raw, d_eff, d_eff_next;
    logic             p_ace, d_ace;
    logic [CNT_W-1:0] p_cnt, d_cnt;
    logic             card_ok;

    assign card_ok = rank_valid(card_value);

    hand_accumulator #(.MAX_CARDS(MAX_CARDS), .CNT_W(CNT_W)) u_player (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (p_clear),
        .add_i      (p_add),
        .rank_i     (card_value),
        .raw_o      (p_raw),
        .ace_o      (p_ace),
        .eff_o      (p_eff),
        .count_o    (p_cnt),
        .eff_next_o (p_eff_next)
    );

    hand_accumulator #(.MAX_CARDS(MAX_CARDS), .CNT_W(CNT_W)) u_dealer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (d_clear),
        .add_i      (d_add),
        .rank_i     (card_value),
        .raw_o      (d_raw),
        .ace_o      (d_ace),
        .eff_o      (d_eff),
        .count_o    (d_cnt),
        .eff_next_o (d_eff_next)
    );

    // Raw/ace views and the dealer look-ahead are not needed for sequencing.
    logic unused_hand_bits;
    assign unused_hand_bits = ^{p_raw, p_ace, d_raw, d_ace, d_eff_next};

    // Next-state, hand control and outcome selection.
    always_comb begin
        state_d   = state_q;
        outcome_d = outcome_q;
        show_d    = show_q;
        p_clear   = 1'b0;
        d_clear   = 1'b0;
        p_add     = 1'b0;
        d_add     = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (deal_pressed) begin
                    p_clear   = 1'b1;
                    d_clear   = 1'b1;
                    show_d    = 1'b0;
                    outcome_d = GS_IDLE;
                    state_d   = ST_DEAL_P1;
                end
            end
            ST_DEAL_P1: begin
                if (card_ok) begin
                    p_add   = 1'b1;
                    state_d = ST_DEAL_D1;
                end
            end
            ST_DEAL_D1: begin
                if (card_ok) begin
                    d_add   = 1'b1;
                    state_d = ST_DEAL_P2;
                end
            end
            ST_DEAL_P2: begin
                if (card_ok) begin
                    p_add   = 1'b1;
                    show_d  = 1'b1;
                    state_d = ST_DEAL_D2;
                end
            end
            ST_DEAL_D2: begin
                // Player hand is already complete here, so the registered total decides.
                if (card_ok) begin
                    d_add = 1'b1;
                    if (p_eff == BJ_TARGET) begin
                        show_d  = 1'b0;
                        state_d = ST_DEALER;
                    end else begin
                        state_d = ST_PLAYER;
                    end
                end
            end
            ST_PLAYER: begin
                // Stand has priority over a simultaneous hit.
                if (stand_pressed) begin
                    show_d  = 1'b0;
                    state_d = ST_DEALER;
                end else if (hit_pressed && (p_cnt < MAX_CNT)) begin
                    state_d = ST_P_DRAW;
                end
            end
            ST_P_DRAW: begin
                // Judged on the total including the card being accepted now.
                if (card_ok) begin
                    p_add = 1'b1;
                    if (p_eff_next > BJ_TARGET) begin
                        show_d    = 1'b0;
                        outcome_d = GS_D_WIN;
                        state_d   = ST_RESULT;
                    end else if (p_eff_next == BJ_TARGET) begin
                        show_d  = 1'b0;
                        state_d = ST_DEALER;
                    end else begin
                        state_d = ST_PLAYER;
                    end
                end
            end
            ST_DEALER: begin
                if ((d_eff < STAND_PTS) && (d_cnt < MAX_CNT)) begin
                    state_d = ST_D_DRAW;
                end else begin
                    outcome_d = judge(p_eff, d_eff);
                    state_d   = ST_RESULT;
                end
            end
            ST_D_DRAW: begin
                if (card_ok) begin
                    d_add   = 1'b1;
                    state_d = ST_DEALER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gs_d = state_to_gs(state_d, outcome_d);
    end

    // State and registered outputs; reset aborts any round in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            outcome_q   <= GS_IDLE;
            show_q      <= 1'b0;
            gs_q        <= GS_IDLE;
            taken_q     <= 1'b0;
            to_dealer_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            outcome_q   <= outcome_d;
            show_q      <= show_d;
            gs_q        <= gs_d;
            taken_q     <= p_add | d_add;
            to_dealer_q <= d_add;
        end
    end

    assign player_score      = p_eff;
    assign dealer_score      = d_eff;
    assign game_state        = gs_q;
    assign show_dealer_first = show_q;
    assign card_taken        = taken_q;
    assign card_to_dealer    = to_dealer_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: table of whole rounds plus hand-written corner cases.
module tb_deal_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       deal_pressed, hit_pressed, stand_pressed;
    logic [3:0] card_value;
    logic [4:0] player_score, dealer_score;
    logic [2:0] game_state;
    logic       show_dealer_first, card_taken, card_to_dealer;

    deal_sequencer #(.DEALER_STAND(17), .MAX_CARDS(11)) dut (
        .clk               (clk),
        .reset             (reset),
        .deal_pressed      (deal_pressed),
        .hit_pressed       (hit_pressed),
        .stand_pressed     (stand_pressed),
        .card_value        (card_value),
        .player_score      (player_score),
        .dealer_score      (dealer_score),
        .game_state        (game_state),
        .show_dealer_first (show_dealer_first),
        .card_taken        (card_taken),
        .card_to_dealer    (card_to_dealer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][3:0] cards;
        int hits;
        int gs;
        int ps;
        int ds;
        int takes;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] rng_seq [16];
    int         idx;
    bit         rng_en;
    int         ntaken;
    vec_t       vecs [10];

    function automatic vec_t mk(input logic [3:0] c0, c1, c2, c3, c4, c5, c6, c7,
                                input int hits, gs, ps, ds, takes);
        vec_t v;
        v.cards = {c7, c6, c5, c4, c3, c2, c1, c0};
        v.hits  = hits;
        v.gs    = gs;
        v.ps    = ps;
        v.ds    = ds;
        v.takes = takes;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; the RNG model only advances when the DUT reports a take.
    task automatic step();
        @(posedge clk);
        #1;
        if (card_taken) begin
            ntaken++;
            if (idx < 15) idx++;
        end
        if (rng_en) card_value = rng_seq[idx];
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        deal_pressed  = 1'b0;
        hit_pressed   = 1'b0;
        stand_pressed = 1'b0;
        rng_en        = 1'b0;
        card_value    = 4'd0;
        step();
        step();
        reset  = 1'b0;
        ntaken = 0;
        idx    = 0;
    endtask

    task automatic load(input logic [7:0][3:0] cards);
        for (int i = 0; i < 16; i++) rng_seq[i] = (i < 8) ? cards[i] : 4'd0;
        idx        = 0;
        rng_en     = 1'b1;
        card_value = rng_seq[0];
    endtask

    task automatic wait_gs(input int want, input string name);
        for (int g = 0; g < 30 && game_state != 3'(want); g++) step();
        check(name, game_state, want);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int hits_left;
        bit pending, stood, done;
        do_reset();
        load(v.cards);
        deal_pressed = 1'b1;
        step();
        deal_pressed = 1'b0;
        hits_left = v.hits;
        pending   = 1'b0;
        stood     = 1'b0;
        done      = 1'b0;
        for (int guard = 0; guard < 200 && !done; guard++) begin
            hit_pressed   = 1'b0;
            stand_pressed = 1'b0;
            if (game_state == 3'd2 && !pending) begin
                if (hits_left > 0) begin
                    hit_pressed = 1'b1;
                    hits_left--;
                    pending = 1'b1;
                end else if (!stood) begin
                    stand_pressed = 1'b1;
                    stood   = 1'b1;
                    pending = 1'b1;
                end
            end
            step();
            if (card_taken && !card_to_dealer) pending = 1'b0;
            if (game_state >= 3'd4) done = 1'b1;
        end
        hit_pressed   = 1'b0;
        stand_pressed = 1'b0;
        check($sformatf("v%0d_done", k), done, 1);
        for (int i = 0; i < 3; i++) step();
        check($sformatf("v%0d_game_state", k), game_state, v.gs);
        check($sformatf("v%0d_player_score", k), player_score, v.ps);
        check($sformatf("v%0d_dealer_score", k), dealer_score, v.ds);
        check($sformatf("v%0d_show_dealer_first", k), show_dealer_first, 0);
        check($sformatf("v%0d_cards_taken", k), ntaken, v.takes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_take;

        //             cards                                 hits gs  ps  ds takes
        vecs[0] = mk(10,  5,  1,  6,  7,  0,  0, 0,          0,  4, 21, 18, 5);
        vecs[1] = mk(10, 10,  7,  7,  0,  0,  0, 0,          0,  6, 17, 17, 4);
        vecs[2] = mk(10,  9,  6,  8, 10,  0,  0, 0,          1,  5, 26, 17, 5);
        vecs[3] = mk(10,  1,  9,  6,  0,  0,  0, 0,          0,  4, 19, 17, 4);
        vecs[4] = mk(10,  1,  8,  5, 10,  5,  0, 0,          0,  5, 18, 21, 6);
        vecs[5] = mk(10, 10,  8,  6, 10,  0,  0, 0,          0,  4, 18, 26, 5);
        vecs[6] = mk( 5, 10,  6,  7, 10,  0,  0, 0,          1,  4, 21, 17, 5);
        vecs[7] = mk(13, 12,  6, 11,  0,  0,  0, 0,          0,  5, 16, 20, 4);
        vecs[8] = mk( 1, 10,  1,  7,  9,  0,  0, 0,          1,  4, 21, 17, 5);
        vecs[9] = mk( 2, 10,  3,  7,  4,  5,  0, 0,          2,  5, 14, 17, 6);

        // Reset values.
        do_reset();
        check("rst_player_score", player_score, 0);
        check("rst_dealer_score", dealer_score, 0);
        check("rst_game_state", game_state, 0);
        check("rst_show_dealer_first", show_dealer_first, 0);
        check("rst_card_taken", card_taken, 0);
        check("rst_card_to_dealer", card_to_dealer, 0);

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Deal timing: four takes on consecutive cycles, P D P D.
        do_reset();
        load({4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd10, 4'd10});
        deal_pressed = 1'b1;
        step();
        deal_pressed = 1'b0;
        check("deal_off0_taken", card_taken, 0);
        check("deal_off0_state", game_state, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("deal_off%0d_taken", k), card_taken, 1);
            check($sformatf("deal_off%0d_to_dealer", k), card_to_dealer, (k % 2 == 0) ? 1 : 0);
            if (k == 1) check("deal_off1_player_score", player_score, 10);
            if (k == 2) check("deal_off2_show", show_dealer_first, 0);
            if (k == 3) check("deal_off3_show", show_dealer_first, 1);
            if (k == 4) check("deal_off4_state", game_state, 2);
        end
        stand_pressed = 1'b1;
        step();
        stand_pressed = 1'b0;
        check("stand_state", game_state, 3);
        check("stand_show", show_dealer_first, 0);
        step();
        check("stand_result", game_state, 6);
        check("stand_no_draw", ntaken, 4);

        // Invalid RNG values stall DEAL_P1.
        do_reset();
        card_value   = 4'd0;
        deal_pressed = 1'b1;
        step();
        deal_pressed = 1'b0;
        saw_take = 1'b0;
        for (int i = 0; i < 10; i++) begin
            card_value = (i < 5) ? 4'd0 : 4'd14;
            step();
            if (card_taken) saw_take = 1'b1;
        end
        check("stall_no_take", saw_take, 0);
        check("stall_state", game_state, 1);
        check("stall_player_score", player_score, 0);
        card_value = 4'd3;
        step();
        check("release_taken", card_taken, 1);
        check("release_to_dealer", card_to_dealer, 0);
        check("release_player_score", player_score, 3);

        // Hit and stand together: stand wins, no card for the player.
        do_reset();
        load({4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd5, 4'd10, 4'd10});
        deal_pressed = 1'b1;
        step();
        deal_pressed = 1'b0;
        wait_gs(2, "hs_reach_player");
        hit_pressed   = 1'b1;
        stand_pressed = 1'b1;
        step();
        hit_pressed   = 1'b0;
        stand_pressed = 1'b0;
        check("hs_state", game_state, 3);
        wait_gs(5, "hs_result");
        check("hs_takes", ntaken, 4);
        check("hs_player_score", player_score, 15);

        // Reset while the dealer is drawing.
        do_reset();
        load({4'd0, 4'd0, 4'd5, 4'd5, 4'd2, 4'd6, 4'd10, 4'd10});
        deal_pressed = 1'b1;
        step();
        deal_pressed = 1'b0;
        wait_gs(2, "rd_reach_player");
        stand_pressed = 1'b1;
        step();
        stand_pressed = 1'b0;
        step();
        check("rd_in_draw_state", game_state, 3);
        check("rd_in_draw_taken", card_taken, 0);
        check("rd_dealer_before", dealer_score, 12);
        reset        = 1'b1;
        deal_pressed = 1'b1;
        step();
        check("rd_player_score", player_score, 0);
        check("rd_dealer_score", dealer_score, 0);
        check("rd_game_state", game_state, 0);
        check("rd_show", show_dealer_first, 0);
        check("rd_card_taken", card_taken, 0);
        check("rd_card_to_dealer", card_to_dealer, 0);
        step();
        deal_pressed = 1'b0;
        reset        = 1'b0;
        step();
        check("rd_deal_ignored", game_state, 0);
        check("rd_no_take", card_taken, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
